// File: rtl/fc84_issue_ctrl_pkg.sv
// Shared constants and state encoding for the FC84 issue controller.
package fc_pkg;
    localparam int N       = 84;
    localparam int DW      = 16;
    localparam int BW      = 16;
    localparam int OW      = 16;
    localparam int NUM_OUT = 10;
    localparam int AW      = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fc_state_e;
endpackage

// File: rtl/fc84_vec_loader.sv
// Serial-to-parallel activation capture with frame-length checking and zero-fill.
module fc84_vec_loader #(
    parameter int N  = fc_pkg::N,
    parameter int DW = fc_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic [N*DW-1:0] vec,
    output logic          frame_done,
    output logic          err
);
    localparam int CW = $clog2(N);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N*DW-1:0] vec_q, vec_d;
    logic            err_q, err_d;
    logic            beat, at_end;

    always_comb begin
        beat       = s_valid & load_en;
        at_end     = (cnt_q == CW'(N - 1));
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        err_d      = err_q;
        frame_done = 1'b0;
        if (beat) begin
            // First beat of a frame starts with a clean error flag.
            if (cnt_q == '0) err_d = 1'b0;
            vec_d[int'(cnt_q)*DW +: DW] = s_data;
            if (at_end || s_last) begin
                frame_done = 1'b1;
                cnt_d      = '0;
                if (at_end != s_last) err_d = 1'b1;
                for (int k = 0; k < N; k++)
                    if (k > int'(cnt_q)) vec_d[k*DW +: DW] = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            vec_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            vec_q <= vec_d;
            err_q <= err_d;
        end
    end

    assign vec = vec_q;
    assign err = err_q;
endmodule

// File: rtl/fc84_issue_ctrl.sv
// Loads an activation vector, streams NUM_OUT weight rows to the dot-product
// unit, and tags the returned results in order.
module fc84_issue_ctrl #(
    parameter int N       = fc_pkg::N,
    parameter int DW      = fc_pkg::DW,
    parameter int BW      = fc_pkg::BW,
    parameter int NUM_OUT = fc_pkg::NUM_OUT,
    parameter int OW      = fc_pkg::OW,
    parameter int AW      = fc_pkg::AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    input  logic            s_last,
    output logic            w_rd_en,
    output logic [AW-1:0]   w_addr,
    input  logic [N*DW-1:0] w_rdata,
    input  logic [BW-1:0]   b_rdata,
    output logic            fc_valid,
    output logic [N*DW-1:0] fc_in,
    output logic [N*DW-1:0] fc_weights,
    output logic [BW-1:0]   fc_bias,
    input  logic            fc_res_valid,
    input  logic [OW-1:0]   fc_res,
    output logic            res_valid,
    output logic [AW-1:0]   res_idx,
    output logic [OW-1:0]   res_data,
    output logic            done,
    output logic            err
);
    import fc_pkg::*;

    fc_state_e       state_q, state_d;
    logic            w_rd_en_q, w_rd_en_d;
    logic [AW-1:0]   w_addr_q, w_addr_d;
    logic [AW-1:0]   ret_cnt_q, ret_cnt_d;
    logic [1:0]      vld_pipe_q, vld_pipe_d;
    logic [N*DW-1:0] fc_weights_q, fc_weights_d;
    logic [BW-1:0]   fc_bias_q, fc_bias_d;
    logic            res_valid_q, res_valid_d;
    logic [AW-1:0]   res_idx_q, res_idx_d;
    logic [OW-1:0]   res_data_q, res_data_d;
    logic            done_q, done_d;
    logic            frame_done, res_take;

    assign s_ready = (state_q == LOAD);

    fc84_vec_loader #(.N(N), .DW(DW)) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (s_ready),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .vec        (fc_in),
        .frame_done (frame_done),
        .err        (err)
    );

    always_comb begin
        state_d      = state_q;
        w_rd_en_d    = 1'b0;
        w_addr_d     = w_addr_q;
        ret_cnt_d    = ret_cnt_q;
        // bit0: read data present on w_rdata, bit1: issue bus valid
        vld_pipe_d   = {vld_pipe_q[0], w_rd_en_q};
        fc_weights_d = fc_weights_q;
        fc_bias_d    = fc_bias_q;
        res_valid_d  = 1'b0;
        res_idx_d    = res_idx_q;
        res_data_d   = res_data_q;
        done_d       = 1'b0;
        res_take     = fc_res_valid && (state_q != LOAD);

        if (vld_pipe_q[0]) begin
            fc_weights_d = w_rdata;
            fc_bias_d    = b_rdata;
        end

        if (res_take) begin
            res_valid_d = 1'b1;
            res_idx_d   = ret_cnt_q;
            res_data_d  = fc_res;
            if (ret_cnt_q == AW'(NUM_OUT - 1)) begin
                done_d    = 1'b1;
                ret_cnt_d = '0;
            end else begin
                ret_cnt_d = ret_cnt_q + 1'b1;
            end
        end

        case (state_q)
            LOAD: if (frame_done) begin
                state_d   = ISSUE;
                w_rd_en_d = 1'b1;
                w_addr_d  = '0;
            end
            ISSUE: if (w_addr_q == AW'(NUM_OUT - 1)) begin
                state_d = DRAIN;
            end else begin
                w_rd_en_d = 1'b1;
                w_addr_d  = w_addr_q + 1'b1;
            end
            DRAIN:   ;
            default: state_d = LOAD;
        endcase

        if (done_d) begin
            state_d   = LOAD;
            w_rd_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            w_rd_en_q    <= 1'b0;
            w_addr_q     <= '0;
            ret_cnt_q    <= '0;
            vld_pipe_q   <= '0;
            fc_weights_q <= '0;
            fc_bias_q    <= '0;
            res_valid_q  <= 1'b0;
            res_idx_q    <= '0;
            res_data_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_rd_en_q    <= w_rd_en_d;
            w_addr_q     <= w_addr_d;
            ret_cnt_q    <= ret_cnt_d;
            vld_pipe_q   <= vld_pipe_d;
            fc_weights_q <= fc_weights_d;
            fc_bias_q    <= fc_bias_d;
            res_valid_q  <= res_valid_d;
            res_idx_q    <= res_idx_d;
            res_data_q   <= res_data_d;
            done_q       <= done_d;
        end
    end

    assign w_rd_en    = w_rd_en_q;
    assign w_addr     = w_addr_q;
    assign fc_valid   = vld_pipe_q[1];
    assign fc_weights = fc_weights_q;
    assign fc_bias    = fc_bias_q;
    assign res_valid  = res_valid_q;
    assign res_idx    = res_idx_q;
    assign res_data   = res_data_q;
    assign done       = done_q;
endmodule

// File: tb/tb_fc84_issue_ctrl.sv
// Bench for fc84_issue_ctrl: weight memory and dot-product unit models plus
// per-scenario checks against a frame-level reference.
module tb_fc84_issue_ctrl;
    localparam int N = 84, DW = 16, BW = 16, NUM_OUT = 10, OW = 16, AW = 4;
    localparam int LAT = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid, s_ready, s_last;
    logic [DW-1:0]   s_data;
    logic            w_rd_en;
    logic [AW-1:0]   w_addr;
    logic [N*DW-1:0] w_rdata;
    logic [BW-1:0]   b_rdata;
    logic            fc_valid;
    logic [N*DW-1:0] fc_in, fc_weights;
    logic [BW-1:0]   fc_bias;
    logic            fc_res_valid;
    logic [OW-1:0]   fc_res;
    logic            res_valid, done, err;
    logic [AW-1:0]   res_idx;
    logic [OW-1:0]   res_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int salt = 0;
    int res_base = 100;
    int issue_n = 0;

    typedef struct { int cyc; int addr; } rd_t;
    typedef struct { int cyc; logic [BW-1:0] bias; logic [N*DW-1:0] w; } fc_t;
    typedef struct { int cyc; int idx; logic [OW-1:0] data; logic dn; } res_t;
    typedef struct { int due; logic [OW-1:0] val; } ret_t;
    rd_t  rd_log[$];
    fc_t  fc_log[$];
    res_t res_log[$];
    ret_t ret_q[$];

    fc84_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata), .b_rdata(b_rdata),
        .fc_valid(fc_valid), .fc_in(fc_in), .fc_weights(fc_weights), .fc_bias(fc_bias),
        .fc_res_valid(fc_res_valid), .fc_res(fc_res),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] row(input int n);
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(n + salt);
        return r;
    endfunction

    // Memory and dot-product unit models; drive after the edge, sample mid-cycle.
    initial begin
        logic pend;
        int   paddr;
        pend = 1'b0; paddr = 0;
        w_rdata = '1; b_rdata = 16'hDEAD; fc_res_valid = 1'b0; fc_res = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (pend) begin
                w_rdata = row(paddr);
                b_rdata = BW'(paddr + salt);
            end else begin
                w_rdata = '1;
                b_rdata = 16'hDEAD;
            end
            fc_res_valid = 1'b0;
            fc_res = OW'($urandom);
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                ret_t r;
                r = ret_q.pop_front();
                fc_res_valid = 1'b1;
                fc_res = r.val;
            end
            @(negedge clk);
            pend  = w_rd_en;
            paddr = int'(w_addr);
            if (w_rd_en) rd_log.push_back('{cyc, int'(w_addr)});
            if (fc_valid) begin
                fc_log.push_back('{cyc, fc_bias, fc_weights});
                ret_q.push_back('{cyc + LAT, OW'(res_base + issue_n)});
                issue_n++;
            end
            if (res_valid) res_log.push_back('{cyc, int'(res_idx), res_data, done});
        end
    end

    task automatic clear_logs();
        rd_log.delete(); fc_log.delete(); res_log.delete();
        issue_n = 0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input bit gaps);
        int guard;
        guard = 0;
        if (gaps) while ($urandom_range(1, 0) == 1) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = d; s_last = last;
        while (s_ready !== 1'b1 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 500) begin
            checks++; errors++;
            $display("FAIL beat_accept: s_ready stayed %b, required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Holds a junk beat on the stream while busy; none of it may be taken.
    task automatic wait_done();
        bit seen, rdy_bad;
        seen = 0; rdy_bad = 0;
        s_valid = 1'b1; s_data = 16'hBAD0; s_last = 1'b1;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1; s_valid = 1'b0; s_last = 1'b0;
            end else if (s_ready !== 1'b0) rdy_bad = 1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL done_timeout: done never 1 within 300 cycles"); end
        checks++;
        if (rdy_bad) begin errors++; $display("FAIL busy_ready: s_ready was 1 while busy, required 0"); end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_done: got %b required 1", s_ready); end
    endtask

    task automatic check_frame(input string nm, input logic [N*DW-1:0] exp_vec, input logic exp_err);
        int rd0, badn;
        checks++;
        if (rd_log.size() != NUM_OUT || fc_log.size() != NUM_OUT || res_log.size() != NUM_OUT) begin
            errors++;
            $display("FAIL %s counts: rd=%0d fc=%0d res=%0d, required %0d each",
                     nm, rd_log.size(), fc_log.size(), res_log.size(), NUM_OUT);
        end else begin
            rd0 = rd_log[0].cyc;
            badn = -1;
            for (int n = NUM_OUT - 1; n >= 0; n--)
                if (rd_log[n].addr != n || rd_log[n].cyc != rd0 + n) badn = n;
            checks++;
            if (badn >= 0) begin
                errors++;
                $display("FAIL %s w_addr_seq: read %0d addr=%0d cyc=%0d, required addr=%0d cyc=%0d",
                         nm, badn, rd_log[badn].addr, rd_log[badn].cyc, badn, rd0 + badn);
            end
            badn = -1;
            for (int n = NUM_OUT - 1; n >= 0; n--)
                if (fc_log[n].cyc != rd0 + 2 + n || fc_log[n].bias !== BW'(n + salt) ||
                    fc_log[n].w !== row(n)) badn = n;
            checks++;
            if (badn >= 0) begin
                errors++;
                $display("FAIL %s fc_issue: pulse %0d cyc=%0d bias=%0h w0=%0h, required cyc=%0d bias=%0h w0=%0h",
                         nm, badn, fc_log[badn].cyc, fc_log[badn].bias, fc_log[badn].w[DW-1:0],
                         rd0 + 2 + badn, BW'(badn + salt), DW'(badn + salt));
            end
            badn = -1;
            for (int n = NUM_OUT - 1; n >= 0; n--)
                if (res_log[n].idx != n || res_log[n].data !== OW'(res_base + n) ||
                    res_log[n].cyc != fc_log[n].cyc + LAT + 1 || res_log[n].dn !== (n == NUM_OUT - 1))
                    badn = n;
            checks++;
            if (badn >= 0) begin
                errors++;
                $display("FAIL %s res_tag: result %0d idx=%0d data=%0h cyc=%0d done=%b, required idx=%0d data=%0h cyc=%0d",
                         nm, badn, res_log[badn].idx, res_log[badn].data, res_log[badn].cyc,
                         res_log[badn].dn, badn, OW'(res_base + badn), fc_log[badn].cyc + LAT + 1);
            end
        end
        badn = -1;
        for (int k = N - 1; k >= 0; k--)
            if (fc_in[k*DW +: DW] !== exp_vec[k*DW +: DW]) badn = k;
        checks++;
        if (badn >= 0) begin
            errors++;
            $display("FAIL %s fc_in: element %0d got %0h required %0h",
                     nm, badn, fc_in[badn*DW +: DW], exp_vec[badn*DW +: DW]);
        end
        checks++;
        if (fc_weights !== row(NUM_OUT - 1) || fc_bias !== BW'(NUM_OUT - 1 + salt)) begin
            errors++;
            $display("FAIL %s issue_hold: bias=%0h w0=%0h, required bias=%0h w0=%0h",
                     nm, fc_bias, fc_weights[DW-1:0], BW'(NUM_OUT - 1 + salt), DW'(NUM_OUT - 1 + salt));
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err: got %b required %b", nm, err, exp_err);
        end
    endtask

    // Sends a frame of len beats (s_last on beat last_at, -1 for none) and checks it.
    task automatic run_frame(input string nm, input int len, input int last_at,
                             input bit seq_data, input bit gaps);
        logic [N*DW-1:0] exp_vec;
        logic [DW-1:0]   d;
        logic            exp_err;
        exp_vec = '0;
        clear_logs();
        for (int k = 0; k < len; k++) begin
            d = seq_data ? DW'(k + 1) : DW'($urandom);
            if (k == last_at && len < N) d = 16'd7;
            exp_vec[k*DW +: DW] = d;
            send_beat(d, k == last_at, gaps);
        end
        exp_err = !(len == N && last_at == N - 1);
        wait_done();
        check_frame(nm, exp_vec, exp_err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({fc_valid, w_rd_en, res_valid, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: fc_valid/w_rd_en/res_valid/done/err=%b required 00000",
                     {fc_valid, w_rd_en, res_valid, done, err});
        end
        checks++;
        if (fc_in !== '0 || fc_weights !== '0 || fc_bias !== '0 || res_data !== '0 || res_idx !== '0) begin
            errors++;
            $display("FAIL reset_data: bias=%0h res_data=%0h res_idx=%0h, required all 0",
                     fc_bias, res_data, res_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", s_ready); end
    endtask

    task automatic test_basic();
        salt = 0; res_base = 100;
        run_frame("basic", N, N - 1, 1'b1, 1'b0);
    endtask

    task automatic test_short_then_gaps();
        salt = int'($urandom_range(20, 1)); res_base = int'($urandom_range(4000, 200));
        run_frame("short", 41, 40, 1'b0, 1'b0);
        // The first accepted beat of the next frame must clear the sticky error.
        clear_logs();
        salt = int'($urandom_range(20, 1)); res_base = int'($urandom_range(4000, 200));
        send_beat(16'd1, 1'b0, 1'b1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", err); end
        begin
            logic [N*DW-1:0] exp_vec;
            for (int k = 0; k < N; k++) exp_vec[k*DW +: DW] = DW'(k + 1);
            for (int k = 1; k < N; k++) send_beat(DW'(k + 1), k == N - 1, 1'b1);
            wait_done();
            check_frame("gaps", exp_vec, 1'b0);
        end
    endtask

    task automatic test_missing_last();
        salt = int'($urandom_range(30, 0)); res_base = int'($urandom_range(9000, 0));
        run_frame("no_last", N, -1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int pulses, late;
        salt = 3; res_base = 500;
        clear_logs();
        for (int k = 0; k < N; k++) send_beat(DW'($urandom), k == N - 1, 1'b0);
        pulses = 0;
        for (int n = 0; n < 50 && pulses < 5; n++) begin
            @(negedge clk);
            if (fc_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 5) begin errors++; $display("FAIL mid_pulses: saw %0d fc_valid pulses, required 5", pulses); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fc_valid, w_rd_en, res_valid, done, err} !== 5'b0 || fc_in !== '0 ||
            fc_weights !== '0 || fc_bias !== '0 || res_data !== '0 || res_idx !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ctrl=%b bias=%0h res_data=%0h, required all 0",
                     {fc_valid, w_rd_en, res_valid, done, err}, fc_bias, res_data);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        late = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || done !== 1'b0) late++;
        end
        checks++;
        if (late != 0) begin errors++; $display("FAIL late_results: res_valid/done high %0d cycles, required 0", late); end
        salt = 9; res_base = 1234;
        run_frame("after_reset", N, N - 1, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_then_gaps();
        test_missing_last();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
